// File: rtl/store_rmw_controller.sv
// store_memory_encoder: turns a latched store (type, byte offset, right-aligned
// data) into a lane-shifted data word and a byte-granular lane mask.
//   type_i   : 00 SB, 01 SH, 10 SW, 11 illegal (mask 0)
//   offset_i : byte offset within the word (addr[1:0])
//   data_i   : right-aligned store data
//   data_o   : data moved into its byte lanes
//   mask_o   : 1 for every bit belonging to a written byte lane
//
// store_rmw_controller: sequences SB/SH/SW onto a word-wide memory port
// without byte enables, using read-modify-write for partial stores and a
// direct write for aligned SW (when FULL_WORD_BYPASS=1).
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : store request handshake (ready only in IDLE)
//   req_type/addr/data  : store type, byte address, right-aligned data
//   mem_valid/mem_ready : memory command handshake
//   mem_we/addr/wdata   : command kind, word address, write data
//   mem_rvalid/rdata    : read response
//   done_valid/done_err : one-cycle completion pulse, err = misaligned/illegal
module store_memory_encoder (
    input  logic [1:0]  type_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] mask_o
);
    logic [4:0] shamt;

    assign shamt = {offset_i, 3'b000};

    // Lane placement; misaligned offsets are never used (error path).
    always_comb begin
        data_o = 32'h0;
        mask_o = 32'h0;
        case (type_i)
            2'b00: begin
                data_o = {24'h0, data_i[7:0]} << shamt;
                mask_o = 32'h0000_00FF << shamt;
            end
            2'b01: begin
                data_o = {16'h0, data_i[15:0]} << shamt;
                mask_o = 32'h0000_FFFF << shamt;
            end
            2'b10: begin
                data_o = data_i;
                mask_o = 32'hFFFF_FFFF;
            end
            default: ;
        endcase
    end
endmodule

module store_rmw_controller #(
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter bit          FULL_WORD_BYPASS = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_type,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_data,
    output logic                  mem_valid,
    input  logic                  mem_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  done_valid,
    output logic                  done_err
);
    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WAIT  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic [1:0]         type_q;
    logic [1:0]         off_q;
    logic [WORD_AW-1:0] waddr_q;
    logic [31:0]        data_q;
    logic [31:0]        merged_q, merged_d;

    logic req_ready_q, req_ready_d;
    logic mem_valid_q, mem_valid_d;
    logic mem_we_q, mem_we_d;
    logic done_valid_q, done_valid_d;
    logic done_err_q, done_err_d;

    logic        accept_c;
    logic        req_err_c;
    logic        bypass_c;
    logic [31:0] enc_data;
    logic [31:0] enc_mask;

    // Encoder sees only latched request fields, so req_* may change after accept.
    store_memory_encoder u_enc (
        .type_i   (type_q),
        .offset_i (off_q),
        .data_i   (data_q),
        .data_o   (enc_data),
        .mask_o   (enc_mask)
    );

    assign accept_c = (state_q == S_IDLE) && req_valid;
    assign bypass_c = FULL_WORD_BYPASS && (req_type == 2'b10) && (req_addr[1:0] == 2'b00);

    // Misaligned or illegal request classification.
    always_comb begin
        req_err_c = 1'b0;
        case (req_type)
            2'b00:   req_err_c = 1'b0;
            2'b01:   req_err_c = req_addr[0];
            2'b10:   req_err_c = (req_addr[1:0] != 2'b00);
            default: req_err_c = 1'b1;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_err_c) begin
                        state_d = S_RESP;
                    end else if (bypass_c) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ:  if (mem_ready)  state_d = S_WAIT;
            S_WAIT:  if (mem_rvalid) state_d = S_WRITE;
            S_WRITE: if (mem_ready)  state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register cleanly.
    // RESP reached straight from IDLE can only be the error path.
    always_comb begin
        req_ready_d  = 1'b0;
        mem_valid_d  = 1'b0;
        mem_we_d     = 1'b0;
        done_valid_d = 1'b0;
        done_err_d   = 1'b0;
        case (state_d)
            S_IDLE:  req_ready_d = 1'b1;
            S_READ:  mem_valid_d = 1'b1;
            S_WRITE: begin
                mem_valid_d = 1'b1;
                mem_we_d    = 1'b1;
            end
            S_RESP: begin
                done_valid_d = 1'b1;
                done_err_d   = (state_q == S_IDLE);
            end
            default: ;
        endcase
    end

    // Merged write word: full SW data on bypass, byte-lane merge on read return.
    always_comb begin
        merged_d = merged_q;
        if (accept_c && bypass_c) begin
            merged_d = req_data;
        end else if ((state_q == S_WAIT) && mem_rvalid) begin
            merged_d = (mem_rdata & ~enc_mask) | (enc_data & enc_mask);
        end
    end

    // Request capture and merge register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            type_q   <= 2'b00;
            off_q    <= 2'b00;
            waddr_q  <= '0;
            data_q   <= 32'h0;
            merged_q <= 32'h0;
        end else begin
            if (accept_c) begin
                type_q  <= req_type;
                off_q   <= req_addr[1:0];
                waddr_q <= req_addr[ADDR_WIDTH-1:2];
                data_q  <= req_data;
            end
            merged_q <= merged_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = merged_q;
    assign done_valid = done_valid_q;
    assign done_err   = done_err_q;
endmodule

// File: tb/tb_store_rmw_controller.sv
// Bench for store_rmw_controller: directed vector table, reset-in-flight
// sequences and randomized stores checked against a byte-level model.
module tb_store_rmw_controller;
    localparam bit BYPASS = 1'b1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        done_valid;
    logic        done_err;

    store_rmw_controller #(
        .ADDR_WIDTH       (32),
        .FULL_WORD_BYPASS (BYPASS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_type   (req_type),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .done_valid (done_valid),
        .done_err   (done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Memory responder configuration (written by the main sequence only).
    int          cfg_rs = 0;
    int          cfg_ws = 0;
    int          cfg_rd = 0;
    logic [31:0] cfg_word = 32'h0;
    bit          spurious_en = 1'b0;

    // Memory responder observations (written by the responder only).
    int          n_reads = 0;
    int          n_writes = 0;
    int          n_valid = 0;
    int          stab_err = 0;
    logic [29:0] w_addr = '0;
    logic [31:0] w_data = '0;
    logic [29:0] r_addr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: per-command ready stalls, read latency, optional stray rvalid.
    initial begin : responder
        bit          rd_pending;
        int          rd_cnt;
        bit          cmd_active;
        int          stall;
        logic [29:0] c_addr;
        logic        c_we;
        logic [31:0] c_wdata;
        rd_pending = 0; rd_cnt = 0; cmd_active = 0; stall = 0;
        c_addr = '0; c_we = 0; c_wdata = '0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rd_pending = 0; cmd_active = 0; mem_ready = 0; mem_rvalid = 0;
            end else begin
                mem_rvalid = 0;
                mem_rdata  = $urandom;
                if (rd_pending) begin
                    if (rd_cnt == 0) begin
                        mem_rvalid = 1; mem_rdata = cfg_word; rd_pending = 0;
                    end else begin
                        rd_cnt--;
                    end
                end else if (spurious_en && $urandom_range(0, 3) == 0) begin
                    mem_rvalid = 1;
                end
                if (mem_valid) begin
                    n_valid++;
                    if (!cmd_active) begin
                        cmd_active = 1;
                        stall   = mem_we ? cfg_ws : cfg_rs;
                        c_addr  = mem_addr; c_we = mem_we; c_wdata = mem_wdata;
                    end else if (mem_addr !== c_addr || mem_we !== c_we || mem_wdata !== c_wdata) begin
                        stab_err++;
                    end
                    if (stall > 0) begin
                        mem_ready = 0; stall--;
                    end else begin
                        mem_ready = 1; cmd_active = 0;
                        if (mem_we) begin
                            n_writes++; w_addr = mem_addr; w_data = mem_wdata;
                        end else begin
                            n_reads++; r_addr = mem_addr; rd_pending = 1; rd_cnt = cfg_rd;
                        end
                    end
                end else begin
                    mem_ready  = 1'($urandom_range(0, 1));
                    cmd_active = 0;
                end
            end
        end
    end

    // Reference model: byte-lane replacement and cycle accounting.
    function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                  input logic [31:0] m, input int rs, input int ws, input int rd,
                                  output bit err, output logic [31:0] w, output int lat,
                                  output int nr, output int nw);
        int size;
        int off;
        logic [7:0] b [4];
        bit bypass;
        off  = int'(a[1:0]);
        size = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : (t == 2'd2) ? 4 : 0;
        err  = (size == 0) || ((off % size) != 0);
        for (int i = 0; i < 4; i++) b[i] = m[8*i +: 8];
        if (!err) for (int i = 0; i < size; i++) b[off+i] = d[8*i +: 8];
        w      = {b[3], b[2], b[1], b[0]};
        bypass = BYPASS && (size == 4) && !err;
        nr  = (err || bypass) ? 0 : 1;
        nw  = err ? 0 : 1;
        lat = err ? 1 : bypass ? (2 + ws) : (4 + rs + rd + ws);
    endfunction

    // Issue one store at a negedge and check everything about its completion.
    task automatic run_store(input string nm, input logic [1:0] t, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] m,
                             input int rs, input int ws, input int rd,
                             input bit e_err, input logic [31:0] e_w, input int e_lat,
                             input int e_nr, input int e_nw);
        int r0, w0, v0, s0, lat;
        bit seen;
        cfg_rs = rs; cfg_ws = ws; cfg_rd = rd; cfg_word = m;
        for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
        chk({nm, " ready"}, 32'(req_ready), 32'd1);
        r0 = n_reads; w0 = n_writes; v0 = n_valid; s0 = stab_err;
        req_valid = 1; req_type = t; req_addr = a; req_data = d;
        lat = 0; seen = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 0; req_type = 2'($urandom); req_addr = $urandom; req_data = $urandom;
            end
            if (done_valid) begin
                lat = k; seen = 1; break;
            end
        end
        chk({nm, " done seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(e_lat));
        chk({nm, " done_err"}, 32'(done_err), 32'(e_err));
        chk({nm, " busy ready"}, 32'(req_ready), 32'd0);
        chk({nm, " reads"}, 32'(n_reads - r0), 32'(e_nr));
        chk({nm, " writes"}, 32'(n_writes - w0), 32'(e_nw));
        chk({nm, " stable"}, 32'(stab_err - s0), 32'd0);
        if (e_nw != 0) begin
            chk({nm, " wdata"}, w_data, e_w);
            chk({nm, " waddr"}, 32'(w_addr), {2'b00, a[31:2]});
        end
        if (e_nr != 0) chk({nm, " raddr"}, 32'(r_addr), {2'b00, a[31:2]});
        if (e_err) chk({nm, " no cmd"}, 32'(n_valid - v0), 32'd0);
        @(negedge clk);
        chk({nm, " pulse len"}, 32'(done_valid), 32'd0);
        chk({nm, " ready after"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] m;
        int          rs;
        int          ws;
        int          rd;
        bit          err;
        logic [31:0] w;
        int          lat;
        int          nr;
        int          nw;
    } vec_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        vec_t        vecs [12];
        int          r0, w0;
        bit          stray;
        bit          e;
        logic [31:0] ew, a, d, m;
        logic [1:0]  t;
        int          el, enr, enw, rs, ws, rd;

        //          t      addr          data          mem           rs ws rd err  wdata         lat nr nw
        vecs[0]  = '{2'd0, 32'h0000_0101, 32'h0000_00AB, 32'h1122_3344, 0, 0, 0, 0, 32'h1122_AB44, 4, 1, 1};
        vecs[1]  = '{2'd1, 32'h0000_0202, 32'h0000_BEEF, 32'hFFFF_FFFF, 0, 0, 0, 0, 32'hBEEF_FFFF, 4, 1, 1};
        vecs[2]  = '{2'd2, 32'h0000_0300, 32'hDEAD_BEEF, 32'h5555_5555, 0, 0, 0, 0, 32'hDEAD_BEEF, 2, 0, 1};
        vecs[3]  = '{2'd1, 32'h0000_0003, 32'h0000_1234, 32'h0,         0, 0, 0, 1, 32'h0,         1, 0, 0};
        vecs[4]  = '{2'd2, 32'h0000_0002, 32'h1234_5678, 32'h0,         0, 0, 0, 1, 32'h0,         1, 0, 0};
        vecs[5]  = '{2'd3, 32'h0000_0000, 32'h1234_5678, 32'h0,         0, 0, 0, 1, 32'h0,         1, 0, 0};
        vecs[6]  = '{2'd1, 32'h0000_0010, 32'h0000_1234, 32'hAAAA_AAAA, 3, 2, 0, 0, 32'hAAAA_1234, 9, 1, 1};
        vecs[7]  = '{2'd0, 32'h0000_0003, 32'h0000_005A, 32'h0000_0000, 0, 0, 0, 0, 32'h5A00_0000, 4, 1, 1};
        vecs[8]  = '{2'd0, 32'h0000_0000, 32'hFFFF_FF77, 32'h1234_5678, 0, 0, 0, 0, 32'h1234_5677, 4, 1, 1};
        vecs[9]  = '{2'd2, 32'h0000_0400, 32'h0BAD_F00D, 32'h0,         0, 2, 0, 0, 32'h0BAD_F00D, 4, 0, 1};
        vecs[10] = '{2'd1, 32'h0000_0001, 32'h0000_CAFE, 32'h0,         0, 0, 0, 1, 32'h0,         1, 0, 0};
        vecs[11] = '{2'd1, 32'hFFFF_FFFE, 32'h0000_CAFE, 32'h0000_0000, 0, 0, 2, 0, 32'hCAFE_0000, 6, 1, 1};

        rst_n = 0; req_valid = 0; req_type = 0; req_addr = 0; req_data = 0;
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst mem_valid", 32'(mem_valid), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst done_valid", 32'(done_valid), 32'd0);
        chk("rst done_err", 32'(done_err), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_store($sformatf("vec%0d", i), vecs[i].t, vecs[i].a, vecs[i].d, vecs[i].m,
                      vecs[i].rs, vecs[i].ws, vecs[i].rd, vecs[i].err, vecs[i].w,
                      vecs[i].lat, vecs[i].nr, vecs[i].nw);
        end

        // Reset while waiting for read data.
        cfg_rs = 0; cfg_ws = 0; cfg_rd = 6; cfg_word = 32'h0;
        r0 = n_reads; w0 = n_writes;
        req_valid = 1; req_type = 2'd0; req_addr = 32'h0000_0105; req_data = 32'h77;
        @(negedge clk);
        req_valid = 0;
        for (int k = 0; k < 20 && n_reads == r0; k++) @(negedge clk);
        @(negedge clk);
        chk("wait pre mem_valid", 32'(mem_valid), 32'd0);
        chk("wait pre req_ready", 32'(req_ready), 32'd0);
        #2 rst_n = 0;
        #1;
        chk("wait rst req_ready", 32'(req_ready), 32'd1);
        chk("wait rst mem_addr", 32'(mem_addr), 32'd0);
        chk("wait rst mem_valid", 32'(mem_valid), 32'd0);
        chk("wait rst done_valid", 32'(done_valid), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_valid) stray = 1;
        end
        chk("wait rst no done", 32'(stray), 32'd0);
        chk("wait rst no write", 32'(n_writes - w0), 32'd0);
        run_store("post wait rst", 2'd0, 32'h0000_0105, 32'h0000_0077, 32'h8899_AABB,
                  0, 0, 0, 0, 32'h8899_77BB, 4, 1, 1);

        // Reset while a write is being held off.
        cfg_rs = 0; cfg_ws = 10; cfg_rd = 0; cfg_word = 32'hFFFF_FFFF;
        w0 = n_writes;
        req_valid = 1; req_type = 2'd1; req_addr = 32'h0000_0020; req_data = 32'h1111;
        @(negedge clk);
        req_valid = 0;
        for (int k = 0; k < 20 && !(mem_valid && mem_we); k++) @(negedge clk);
        chk("write pre mem_valid", 32'(mem_valid && mem_we), 32'd1);
        #2 rst_n = 0;
        #1;
        chk("write rst mem_valid", 32'(mem_valid), 32'd0);
        chk("write rst mem_we", 32'(mem_we), 32'd0);
        chk("write rst mem_wdata", mem_wdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        stray = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done_valid) stray = 1;
        end
        chk("write rst no done", 32'(stray), 32'd0);
        chk("write rst no write", 32'(n_writes - w0), 32'd0);

        // Randomized stores with stray rvalid pulses outside WAIT.
        spurious_en = 1;
        for (int i = 0; i < 200; i++) begin
            t  = 2'($urandom);
            a  = $urandom;
            d  = $urandom;
            m  = $urandom;
            rs = $urandom_range(0, 3);
            ws = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            model(t, a, d, m, rs, ws, rd, e, ew, el, enr, enw);
            run_store($sformatf("rnd%0d", i), t, a, d, m, rs, ws, rd, e, ew, el, enr, enw);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
